// File: rtl/a_buff_pkg.sv
// rtl/a_buff_pkg.sv - shared sizing, state encoding and helpers for the A-buffer loader
package a_buff_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int MEM_DEPTH       = 8;
    localparam int ADDR_WIDTH      = 3;
    localparam int NUM_MACS        = 2;
    localparam int NUM_PEs_PER_ROW = 4;
    localparam int LANE_W          = NUM_MACS * DATA_WIDTH;
    localparam int ROW_W           = NUM_PEs_PER_ROW * LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lane counter width; a single-lane row still needs one bit.
    function automatic int lane_cw(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/a_buff_loader_ctr.sv
// rtl/a_buff_loader_ctr.sv - row/lane position counter with lane wrap and last-beat flag
module a_buff_loader_ctr
    import a_buff_pkg::*;
#(
    parameter int ADDR_WIDTH      = a_buff_pkg::ADDR_WIDTH,
    parameter int NUM_PEs_PER_ROW = a_buff_pkg::NUM_PEs_PER_ROW,
    parameter int LANE_CW         = lane_cw(NUM_PEs_PER_ROW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ADDR_WIDTH:0]   rows,
    output logic [ADDR_WIDTH-1:0] row,
    output logic [LANE_CW-1:0]    lane,
    output logic                  last_beat
);

    localparam logic [LANE_CW-1:0]  LANE_MAX = LANE_CW'(NUM_PEs_PER_ROW - 1);
    localparam logic [ADDR_WIDTH:0] ROWS_ONE = (ADDR_WIDTH + 1)'(1);

    logic lane_wrap;

    assign lane_wrap = (lane == LANE_MAX);
    assign last_beat = lane_wrap && ({1'b0, row} == (rows - ROWS_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            lane <= '0;
        end else if (clear) begin
            row  <= '0;
            lane <= '0;
        end else if (advance) begin
            if (lane_wrap) begin
                lane <= '0;
                row  <= row + 1'b1;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/a_buff_loader.sv
// rtl/a_buff_loader.sv - streams row data into the A-buffer write port; A_BUFF_LOADER_ROW_PACK_EN writes whole rows
module a_buff_loader
    import a_buff_pkg::*;
#(
    parameter int DATA_WIDTH      = a_buff_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH       = a_buff_pkg::MEM_DEPTH,
    parameter int ADDR_WIDTH      = a_buff_pkg::ADDR_WIDTH,
    parameter int NUM_MACS        = a_buff_pkg::NUM_MACS,
    parameter int NUM_PEs_PER_ROW = a_buff_pkg::NUM_PEs_PER_ROW
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [ADDR_WIDTH:0]                        num_rows,
    input  logic [NUM_MACS*DATA_WIDTH-1:0]             s_data,
    input  logic                                       s_valid,
    output logic                                       s_ready,
    output logic [NUM_PEs_PER_ROW*NUM_MACS*DATA_WIDTH-1:0] buf_in,
    output logic [ADDR_WIDTH-1:0]                      buf_addr,
    output logic                                       buf_en,
    output logic [NUM_PEs_PER_ROW-1:0]                 buf_wr,
    output logic                                       busy,
    output logic                                       done
);

    localparam int LANE_BITS = NUM_MACS * DATA_WIDTH;
    localparam int ROW_BITS  = NUM_PEs_PER_ROW * LANE_BITS;
    localparam int LANE_BITS_W = lane_cw(NUM_PEs_PER_ROW);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH:0]     rows_lat;
    logic [ADDR_WIDTH:0]     rows_clip;
    logic [ADDR_WIDTH-1:0]   row;
    logic [LANE_BITS_W-1:0]  lane;
    logic                    last_beat;
    logic                    accept_start;
    logic                    beat;

    assign accept_start = (state == IDLE) && start;
    assign beat         = (state == LOAD) && s_valid;
    assign rows_clip    = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;

    a_buff_loader_ctr #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_PEs_PER_ROW (NUM_PEs_PER_ROW),
        .LANE_CW         (LANE_BITS_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_start),
        .advance   (beat),
        .rows      (rows_lat),
        .row       (row),
        .lane      (lane),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_rows == '0) ? DONE : LOAD;
            LOAD: if (beat && last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state == LOAD);
        busy    = (state != IDLE);
    end

    // done follows the DONE state by one edge so it lands one cycle after the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            rows_lat <= '0;
        end else begin
            done <= (state == DONE);
            if (accept_start) begin
                rows_lat <= rows_clip;
            end
        end
    end

`ifdef A_BUFF_LOADER_ROW_PACK_EN
    logic [ROW_BITS-1:0] stage;
    logic [ROW_BITS-1:0] row_nxt;
    logic                write_row;

    always_comb begin
        row_nxt = stage;
        row_nxt[lane*LANE_BITS +: LANE_BITS] = s_data;
    end

    assign write_row = beat && (lane == LANE_BITS_W'(NUM_PEs_PER_ROW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage    <= '0;
            buf_en   <= 1'b0;
            buf_wr   <= '0;
            buf_in   <= '0;
            buf_addr <= '0;
        end else begin
            buf_en <= write_row;
            buf_wr <= write_row ? '1 : '0;
            if (beat) begin
                stage <= row_nxt;
            end
            if (write_row) begin
                buf_in   <= row_nxt;
                buf_addr <= row;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_en   <= 1'b0;
            buf_wr   <= '0;
            buf_in   <= '0;
            buf_addr <= '0;
        end else begin
            buf_en <= beat;
            buf_wr <= beat ? (NUM_PEs_PER_ROW'(1) << lane) : '0;
            if (beat) begin
                buf_in   <= ROW_BITS'(s_data) << (lane * LANE_BITS);
                buf_addr <= row;
            end
        end
    end
`endif

endmodule

// File: tb/tb_a_buff_loader.sv
// tb/tb_a_buff_loader.sv - directed self-checking bench for a_buff_loader (either build of A_BUFF_LOADER_ROW_PACK_EN)
module tb_a_buff_loader;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    localparam int NM = 2;
    localparam int NP = 4;
    localparam int LW = NM * DW;
    localparam int RW = NP * LW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW:0]   num_rows;
    logic [LW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [RW-1:0] buf_in;
    logic [AW-1:0] buf_addr;
    logic          buf_en;
    logic [NP-1:0] buf_wr;
    logic          busy;
    logic          done;

    a_buff_loader #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .NUM_MACS(NM), .NUM_PEs_PER_ROW(NP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .buf_in(buf_in), .buf_addr(buf_addr), .buf_en(buf_en),
        .buf_wr(buf_wr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [NP-1:0] wr;
        logic [RW-1:0] data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  last_wr_cyc = 0;
    wr_t wlog[$];
    wr_t exp_tab[8];
    int  exp_n;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (buf_en) begin
            wlog.push_back('{buf_addr, buf_wr, buf_in});
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!rst) begin
            if (!buf_en) chk("wr_without_en", RW'(buf_wr), '0);
            else         chk("addr_in_range", RW'(buf_addr <= AW'(DEPTH - 1)), RW'(1));
        end
    end

    task automatic start_load(input int n);
        @(posedge clk) #1;
        start = 1'b1;
        num_rows = (AW + 1)'(n);
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input int v);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = LW'(v);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            @(posedge clk) #1;
        end
        chk("beat_accepted", RW'(ok), RW'(1));
    endtask

    task automatic send_beats(input int n, input int base);
        for (int i = 0; i < n; i++) send_beat(base + i);
        s_valid = 1'b0;
    endtask

    task automatic gap();
        s_valid = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", RW'(seen), RW'(1));
        @(posedge clk) #1;
    endtask

    initial begin
        int d0;
        logic [RW-1:0] e;

`ifdef A_BUFF_LOADER_ROW_PACK_EN
        exp_n = 2;
        exp_tab[0] = '{3'd0, 4'b1111, 64'h0004_0003_0002_0001};
        exp_tab[1] = '{3'd1, 4'b1111, 64'h0008_0007_0006_0005};
`else
        exp_n = 8;
        exp_tab[0] = '{3'd0, 4'b0001, 64'h0000_0000_0000_0001};
        exp_tab[1] = '{3'd0, 4'b0010, 64'h0000_0000_0002_0000};
        exp_tab[2] = '{3'd0, 4'b0100, 64'h0000_0003_0000_0000};
        exp_tab[3] = '{3'd0, 4'b1000, 64'h0004_0000_0000_0000};
        exp_tab[4] = '{3'd1, 4'b0001, 64'h0000_0000_0000_0005};
        exp_tab[5] = '{3'd1, 4'b0010, 64'h0000_0000_0006_0000};
        exp_tab[6] = '{3'd1, 4'b0100, 64'h0000_0007_0000_0000};
        exp_tab[7] = '{3'd1, 4'b1000, 64'h0008_0000_0000_0000};
`endif

        rst = 1'b1; start = 1'b0; num_rows = '0; s_data = '0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {buf_in, 4'(buf_addr), buf_wr}, '0);
        chk("rst_flags", RW'({buf_en, s_ready, busy, done}), '0);
        @(posedge clk) #1;
        rst = 1'b0;

        // two rows, eight back-to-back beats
        wlog.delete();
        start_load(2);
        send_beats(8, 1);
        wait_done(20);
        chk("basic_nwrites", RW'(wlog.size()), RW'(exp_n));
        for (int i = 0; i < exp_n && i < wlog.size(); i++) begin
            chk($sformatf("basic_addr%0d", i), RW'(wlog[i].addr), RW'(exp_tab[i].addr));
            chk($sformatf("basic_wr%0d", i), RW'(wlog[i].wr), RW'(exp_tab[i].wr));
            chk($sformatf("basic_data%0d", i), wlog[i].data, exp_tab[i].data);
        end
        chk("done_after_last_write", RW'(done_cyc - last_wr_cyc), RW'(1));
        chk("idle_after_done", RW'({s_ready, busy}), '0);

        // valid gaps hold the counters
        wlog.delete();
        start_load(1);
        send_beat(32'h11); gap();
        send_beat(32'h22); gap();
        send_beat(32'h33); gap();
        send_beat(32'h44);
        s_valid = 1'b0;
        wait_done(20);
`ifdef A_BUFF_LOADER_ROW_PACK_EN
        chk("gap_nwrites", RW'(wlog.size()), RW'(1));
        if (wlog.size() > 0) chk("gap_row", wlog[0].data, 64'h0044_0033_0022_0011);
`else
        chk("gap_nwrites", RW'(wlog.size()), RW'(4));
        if (wlog.size() == 4) begin
            chk("gap_wr0", RW'(wlog[0].wr), RW'(4'b0001));
            chk("gap_wr1", RW'(wlog[1].wr), RW'(4'b0010));
            chk("gap_wr3", RW'(wlog[3].wr), RW'(4'b1000));
            chk("gap_data2", wlog[2].data, 64'h0000_0033_0000_0000);
        end
`endif

        // zero rows: one busy cycle, done, no writes
        wlog.delete();
        d0 = done_cnt;
        @(posedge clk) #1;
        start = 1'b1; num_rows = '0;
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_busy", RW'({busy, done}), RW'(2'b10));
        @(negedge clk);
        chk("zero_done", RW'({busy, done}), RW'(2'b01));
        @(negedge clk);
        chk("zero_done_once", RW'(done_cnt - d0), RW'(1));
        chk("zero_nwrites", RW'(wlog.size()), '0);

        // twelve rows requested, clipped to the buffer depth
        wlog.delete();
        start_load(12);
        send_beats(32, 1);
        wait_done(20);
        @(negedge clk);
        chk("clip_s_ready_low", RW'(s_ready), '0);
`ifdef A_BUFF_LOADER_ROW_PACK_EN
        chk("clip_nwrites", RW'(wlog.size()), RW'(8));
        e = 64'h0020_001f_001e_001d;
`else
        chk("clip_nwrites", RW'(wlog.size()), RW'(32));
        e = 64'h0020_0000_0000_0000;
`endif
        if (wlog.size() > 0) begin
            chk("clip_last_addr", RW'(wlog[wlog.size()-1].addr), RW'(7));
            chk("clip_last_data", wlog[wlog.size()-1].data, e);
        end

        // reset in the middle of a load
        wlog.delete();
        d0 = done_cnt;
        start_load(2);
        send_beats(5, 1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {buf_in, 4'(buf_addr), buf_wr}, '0);
        chk("midrst_flags", RW'({buf_en, s_ready, busy, done}), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", RW'(done_cnt - d0), '0);
`ifdef A_BUFF_LOADER_ROW_PACK_EN
        chk("midrst_nwrites", RW'(wlog.size()), RW'(1));
`else
        chk("midrst_nwrites", RW'(wlog.size()), RW'(4));
`endif
        wlog.delete();
        start_load(1);
        send_beats(4, 9);
        wait_done(20);
        if (wlog.size() > 0) begin
            chk("reload_addr", RW'(wlog[0].addr), '0);
`ifdef A_BUFF_LOADER_ROW_PACK_EN
            chk("reload_wr", RW'(wlog[0].wr), RW'(4'b1111));
            chk("reload_data", wlog[0].data, 64'h000c_000b_000a_0009);
`else
            chk("reload_wr", RW'(wlog[0].wr), RW'(4'b0001));
            chk("reload_data", wlog[0].data, 64'h0000_0000_0000_0009);
`endif
        end else begin
            chk("reload_nwrites", RW'(wlog.size()), RW'(1));
        end

        // start pulsed during LOAD is ignored
        wlog.delete();
        start_load(2);
        send_beats(2, 1);
        start = 1'b1; num_rows = 4'd1;
        @(posedge clk) #1;
        start = 1'b0;
        send_beats(6, 3);
        wait_done(20);
`ifdef A_BUFF_LOADER_ROW_PACK_EN
        chk("ign_nwrites", RW'(wlog.size()), RW'(2));
        e = 64'h0008_0007_0006_0005;
`else
        chk("ign_nwrites", RW'(wlog.size()), RW'(8));
        e = 64'h0008_0000_0000_0000;
`endif
        if (wlog.size() > 0) begin
            chk("ign_last_addr", RW'(wlog[wlog.size()-1].addr), RW'(1));
            chk("ign_last_data", wlog[wlog.size()-1].data, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/a_buff_loader.md
A_BUFF_LOADER -- requirements
Module: a_buff_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 8, number of A-buffer rows.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, A-buffer address width.
REQ-004 SHALL have parameter NUM_MACS, default 2, elements per PE lane.
REQ-005 SHALL have parameter NUM_PEs_PER_ROW, default 4, lanes per buffer row.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk  input  1  clock; rst  input  1  reset.
REQ-007 SHALL have start  input  1  one-cycle request to begin a load.
REQ-008 SHALL have num_rows  input  ADDR_WIDTH+1  rows to load, sampled on an accepted start.
REQ-009 SHALL have s_data  input  NUM_MACS*DATA_WIDTH  one lane of row data per beat.
REQ-010 SHALL have s_valid  input  1  and s_ready  output  1; a beat transfers when both are high at a clk rising edge.
REQ-011 SHALL have buf_in  output  NUM_PEs_PER_ROW*NUM_MACS*DATA_WIDTH, buf_addr  output  ADDR_WIDTH, buf_en  output  1 and buf_wr  output  NUM_PEs_PER_ROW, which drive the A-buffer write port.
REQ-012 SHALL have busy  output  1  (state is not IDLE) and done  output  1  (one-cycle completion pulse).

Function
REQ-013 SHALL implement the states IDLE, LOAD and DONE.
REQ-014 In IDLE, start SHALL latch min(num_rows, MEM_DEPTH), clear the row and lane counters, and enter LOAD. If num_rows is 0, it SHALL enter DONE instead, with no writes.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 s_ready SHALL be high exactly when the state is LOAD.
REQ-017 Beats SHALL fill lanes 0..NUM_PEs_PER_ROW-1 in order. Lane k occupies buf_in bits [(k+1)*NUM_MACS*DATA_WIDTH-1 : k*NUM_MACS*DATA_WIDTH].
REQ-018 The lane counter SHALL wrap from NUM_PEs_PER_ROW-1 to 0 and increment the row counter.
REQ-019 After the last lane of the last row is accepted, the state SHALL go to DONE on the next edge and s_ready SHALL be low from then on.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 All buf_* outputs SHALL be registered.
REQ-022 buf_en and buf_wr SHALL be single-cycle pulses and SHALL be 0 in every cycle without a write.
REQ-023 buf_addr SHALL equal the row counter value of the row being written. It SHALL never exceed MEM_DEPTH-1.
REQ-024 A cycle with s_valid low in LOAD SHALL leave the counters unchanged and produce no write.

Reset
REQ-025 On rst high, the block SHALL asynchronously enter IDLE.
REQ-026 On rst high, the counters SHALL clear and s_ready, buf_en, buf_wr, buf_in, buf_addr, busy and done SHALL all be 0.
REQ-027 A reset during LOAD SHALL discard any partial row with no further writes, and done SHALL not pulse.

Configuration
REQ-028 The block SHALL support the macro A_BUFF_LOADER_ROW_PACK_EN, which selects how each row is written.
REQ-029 Without A_BUFF_LOADER_ROW_PACK_EN, each accepted beat SHALL produce one write on the following cycle, with buf_en=1, buf_wr one-hot at the beat's lane and s_data placed in that lane.
REQ-030 With A_BUFF_LOADER_ROW_PACK_EN, beats SHALL accumulate in a staging register. The cycle after the last lane of a row is accepted, one write SHALL occur with buf_wr all ones and the full staged row on buf_in.

Structure
REQ-031 DATA_WIDTH, NUM_MACS, NUM_PEs_PER_ROW, MEM_DEPTH, ADDR_WIDTH, the derived LANE_W and ROW_W, and the state enumeration SHALL reside in the shared package a_buff_pkg.
REQ-032 The row and lane counter with wrap and last-beat flag SHALL be one sub-module, a_buff_loader_ctr.

Verification
REQ-033 The bench SHALL cover this case, with macro off, reset released: start with num_rows=2, then 8 back-to-back beats 1..8 → 8 writes. Row 0 gets wr=0001,0010,0100,1000, row 1 the same. done pulses 1 cycle after the last write.
REQ-034 The bench SHALL cover this case, with macro on: the same stimulus → exactly 2 writes, both wr=1111. The addr 0 row holds lanes {4,3,2,1} and the addr 1 row holds {8,7,6,5}, MSB lane first.
REQ-035 The bench SHALL cover this case: s_valid toggled 1,0,1,0 during LOAD → writes only for the valid cycles, with the counters held across the gaps.
REQ-036 The bench SHALL cover this case: num_rows=0 → busy for 1 cycle, done pulses, no buf_en. A separate run with num_rows=12 SHALL end with exactly MEM_DEPTH=8 rows written and last buf_addr=7.
REQ-037 The bench SHALL cover this case: rst asserted after 5 beats → all outputs 0 immediately and no done pulse. A new start then loads from addr 0, lane 0.
REQ-038 The bench SHALL cover this case: start pulsed during LOAD → ignored, with row and lane counts unaffected.
